// File: rtl/mem_if_pkg.sv
// Shared constants for the mem request sequencer.
// Data width, FSM state codes and the default read latency.
package mem_if_pkg;
  localparam int DATA_W       = 16;
  localparam int READ_LAT_DEF = 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WR   = 2'd1;
  localparam logic [1:0] RD   = 2'd2;
  localparam logic [1:0] RSP  = 2'd3;
endpackage

// File: rtl/mem_ctrl.sv
// Single-outstanding load/store sequencer in front of the mem block.
// All outputs are registered; strobes never overlap.
module mem_ctrl
  import mem_if_pkg::*;
#(
  parameter int ADDR_W   = 8,
  parameter int READ_LAT = READ_LAT_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              MemWrite,
  output logic              MemRead,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout
);

  localparam int CNT_W = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(READ_LAT - 1);

  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              ready_q, ready_d;
  logic              rsp_q, rsp_d;
  logic              mw_q, mw_d;
  logic              mr_q, mr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] din_q, din_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              accept;
  logic              rd_last;

  assign accept  = (state_q == IDLE) && req_valid && ready_q;
  assign rd_last = (cnt_q == CNT_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (accept) state_d = req_we ? WR : RD;
      WR:   state_d = RSP;
      RD:   if (rd_last) state_d = RSP;
      RSP:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Next values of the registered outputs; read data is sampled
  // on the edge that closes the last MemRead cycle.
  always_comb begin
    ready_d = 1'b0;
    rsp_d   = 1'b0;
    mw_d    = 1'b0;
    mr_d    = 1'b0;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    din_d   = din_q;
    rdata_d = rdata_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          addr_d = req_addr;
          din_d  = req_wdata;
          mw_d   = req_we;
          mr_d   = !req_we;
          cnt_d  = '0;
        end else begin
          ready_d = 1'b1;
        end
      end
      WR: rsp_d = 1'b1;
      RD: begin
        if (rd_last) begin
          rsp_d   = 1'b1;
          rdata_d = mem_dout;
        end else begin
          mr_d  = 1'b1;
          cnt_d = cnt_q + 1'b1;
        end
      end
      RSP: ready_d = 1'b1;
      default: ready_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q   <= '0;
      ready_q <= 1'b0;
      rsp_q   <= 1'b0;
      mw_q    <= 1'b0;
      mr_q    <= 1'b0;
      addr_q  <= '0;
      din_q   <= '0;
      rdata_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
      rsp_q   <= rsp_d;
      mw_q    <= mw_d;
      mr_q    <= mr_d;
      addr_q  <= addr_d;
      din_q   <= din_d;
      rdata_q <= rdata_d;
    end
  end

  assign req_ready = ready_q;
  assign rsp_valid = rsp_q;
  assign rsp_rdata = rdata_q;
  assign MemWrite  = mw_q;
  assign MemRead   = mr_q;
  assign mem_addr  = addr_q;
  assign mem_din   = din_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Bench for mem_ctrl: two instances (READ_LAT 1 and 3) checked
// every cycle against a transaction-timing model.
module tb_mem_ctrl;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]  req_valid = '0;
  logic [1:0]  req_we = '0;
  logic [7:0]  req_addr [2];
  logic [15:0] req_wdata [2];
  logic [1:0]  req_ready, rsp_valid, mwr, mrd;
  logic [15:0] rrd [2];
  logic [7:0]  maddr [2];
  logic [15:0] mdin [2];
  logic [15:0] mdout [2];

  logic [15:0] bmem [2][256];
  logic [15:0] ref_mem [2][256];

  int n_chk = 0;
  int n_fail = 0;

  mem_ctrl #(.ADDR_W(8), .READ_LAT(1)) u_dut0 (
    .clk(clk), .reset(reset),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_we(req_we[0]), .req_addr(req_addr[0]),
    .req_wdata(req_wdata[0]),
    .rsp_valid(rsp_valid[0]), .rsp_rdata(rrd[0]),
    .MemWrite(mwr[0]), .MemRead(mrd[0]),
    .mem_addr(maddr[0]), .mem_din(mdin[0]),
    .mem_dout(mdout[0])
  );

  mem_ctrl #(.ADDR_W(8), .READ_LAT(3)) u_dut1 (
    .clk(clk), .reset(reset),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_we(req_we[1]), .req_addr(req_addr[1]),
    .req_wdata(req_wdata[1]),
    .rsp_valid(rsp_valid[1]), .rsp_rdata(rrd[1]),
    .MemWrite(mwr[1]), .MemRead(mrd[1]),
    .mem_addr(maddr[1]), .mem_din(mdin[1]),
    .mem_dout(mdout[1])
  );

  // Behavioural memories driven by the DUT strobes.
  assign mdout[0] = mrd[0] ? bmem[0][maddr[0]] : 16'h0;
  assign mdout[1] = mrd[1] ? bmem[1][maddr[1]] : 16'h0;

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++)
      if (mwr[i]) bmem[i][maddr[i]] <= mdin[i];
  end

  // Reference model: each accepted request is remembered by the
  // cycle index k it was accepted at; outputs follow from k.
  int cyc = 0;
  int k [2] = '{0, 0};
  bit act [2] = '{0, 0};
  bit up [2] = '{0, 0};
  bit we_m [2] = '{0, 0};
  bit [7:0] ea [2] = '{0, 0};
  bit [15:0] ed [2] = '{0, 0};
  bit [15:0] er [2] = '{0, 0};

  function automatic int lat(int i);
    return (i == 1) ? 3 : 1;
  endfunction

  function automatic int dur(int i);
    return we_m[i] ? 1 : lat(i);
  endfunction

  function automatic bit exp_ready(int i, int c);
    return up[i] && !(act[i] && c <= k[i] + dur(i));
  endfunction

  function automatic bit exp_mw(int i, int c);
    return act[i] && we_m[i] && c == k[i];
  endfunction

  function automatic bit exp_mr(int i, int c);
    return act[i] && !we_m[i] && c >= k[i] && c < k[i] + lat(i);
  endfunction

  function automatic bit exp_rsp(int i, int c);
    return act[i] && c == k[i] + dur(i);
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 2; i++) begin
        up[i] <= 1'b0; act[i] <= 1'b0;
        ea[i] <= '0; ed[i] <= '0; er[i] <= '0;
      end
    end else begin
      cyc <= cyc + 1;
      for (int i = 0; i < 2; i++) begin
        if (act[i] && !we_m[i] && cyc + 1 == k[i] + lat(i))
          er[i] <= ref_mem[i][ea[i]];
        if (req_valid[i] && exp_ready(i, cyc)) begin
          act[i]  <= 1'b1;
          k[i]    <= cyc + 1;
          we_m[i] <= req_we[i];
          ea[i]   <= req_addr[i];
          ed[i]   <= req_wdata[i];
          if (req_we[i]) ref_mem[i][req_addr[i]] <= req_wdata[i];
        end
        up[i] <= 1'b1;
      end
    end
  end

  task automatic chk(string nm, logic [31:0] got, logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", nm, got, want);
    end
  endtask

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("ready%0d c%0d", i, cyc), 32'(req_ready[i]),
          32'(exp_ready(i, cyc)));
      chk($sformatf("rsp%0d c%0d", i, cyc), 32'(rsp_valid[i]),
          32'(exp_rsp(i, cyc)));
      chk($sformatf("mw%0d c%0d", i, cyc), 32'(mwr[i]),
          32'(exp_mw(i, cyc)));
      chk($sformatf("mr%0d c%0d", i, cyc), 32'(mrd[i]),
          32'(exp_mr(i, cyc)));
      chk($sformatf("excl%0d c%0d", i, cyc), 32'(mrd[i] && mwr[i]), 0);
      chk($sformatf("addr%0d c%0d", i, cyc), 32'(maddr[i]), 32'(ea[i]));
      chk($sformatf("din%0d c%0d", i, cyc), 32'(mdin[i]), 32'(ed[i]));
      chk($sformatf("rdata%0d c%0d", i, cyc), 32'(rrd[i]), 32'(er[i]));
    end
  end

  task automatic issue(input int i, input bit we, input logic [7:0] a,
                       input logic [15:0] d);
    int n;
    @(negedge clk);
    req_valid[i] = 1'b1; req_we[i] = we;
    req_addr[i] = a; req_wdata[i] = d;
    n = 0;
    while (!req_ready[i] && n < 30) begin
      @(negedge clk); n++;
    end
    chk("accept timeout", 32'(n >= 30), 0);
    @(negedge clk);
    req_valid[i] = 1'b0;
  endtask

  task automatic do_req(input int i, input bit we, input logic [7:0] a,
                        input logic [15:0] d, output logic [15:0] rd,
                        output int latn);
    issue(i, we, a, d);
    latn = 0;
    while (!rsp_valid[i] && latn < 30) begin
      @(negedge clk); latn++;
    end
    chk("rsp timeout", 32'(latn >= 30), 0);
    rd = rrd[i];
  endtask

  typedef struct {
    int          inst;
    bit          we;
    logic [7:0]  a;
    logic [15:0] d;
    logic [15:0] exp_rd;
    int          exp_lat;
  } vec_t;

  vec_t tbl [6];
  logic [15:0] rd, exp;
  int latn;

  initial begin
    tbl[0] = '{0, 1'b1, 8'h03, 16'h8888, 16'h0000, 1};
    tbl[1] = '{0, 1'b0, 8'h03, 16'h0000, 16'h8888, 1};
    tbl[2] = '{1, 1'b0, 8'h20, 16'h0000, 16'h1111, 3};
    tbl[3] = '{1, 1'b1, 8'h21, 16'h5A5A, 16'h1111, 1};
    tbl[4] = '{1, 1'b0, 8'h21, 16'h0000, 16'h5A5A, 3};
    tbl[5] = '{0, 1'b0, 8'h04, 16'h0000, 16'h0000, 1};

    for (int i = 0; i < 2; i++) begin
      req_addr[i] = '0; req_wdata[i] = '0;
      for (int j = 0; j < 256; j++) begin
        bmem[i][j] = '0; ref_mem[i][j] = '0;
      end
    end
    bmem[1][8'h20] = 16'h1111;
    ref_mem[1][8'h20] = 16'h1111;

    repeat (2) @(negedge clk);
    chk("reset ready0", 32'(req_ready[0]), 0);
    chk("reset rdata1", 32'(rrd[1]), 0);
    reset = 1'b1;
    @(negedge clk);
    chk("ready after release0", 32'(req_ready[0]), 1);
    chk("ready after release1", 32'(req_ready[1]), 1);

    for (int t = 0; t < 6; t++) begin
      do_req(tbl[t].inst, tbl[t].we, tbl[t].a, tbl[t].d, rd, latn);
      chk($sformatf("tbl%0d rdata", t), 32'(rd), 32'(tbl[t].exp_rd));
      chk($sformatf("tbl%0d latency", t), latn, tbl[t].exp_lat);
    end
    chk("mem0 store", 32'(bmem[0][8'h03]), 32'h8888);

    // Store presented while a load is still running.
    issue(1, 1'b0, 8'h20, 16'h0);
    do_req(1, 1'b1, 8'h30, 16'hADAD, rd, latn);
    chk("late store mem", 32'(bmem[1][8'h30]), 32'hADAD);
    chk("late store rdata", 32'(rd), 32'h1111);

    // Reset in the second RD cycle aborts the load.
    issue(1, 1'b0, 8'h21, 16'h0);
    @(negedge clk);
    #1 reset = 1'b0;
    #1;
    chk("abort MemRead", 32'(mrd[1]), 0);
    chk("abort rsp", 32'(rsp_valid[1]), 0);
    chk("abort ready", 32'(req_ready[1]), 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 256; i++) begin
      bmem[1][i] = '0; ref_mem[1][i] = '0;
    end
    bmem[1][8'h21] = 16'h7777;
    ref_mem[1][8'h21] = 16'h7777;
    do_req(1, 1'b0, 8'h21, 16'h0, rd, latn);
    chk("post-reset load", 32'(rd), 32'h7777);
    chk("post-reset latency", latn, 3);

    for (int n = 0; n < 40; n++) begin
      int ii;
      bit w;
      logic [7:0] a;
      logic [15:0] d;
      ii = int'($urandom_range(1, 0));
      w = 1'($urandom_range(1, 0));
      a = 8'($urandom_range(15, 0));
      d = 16'($urandom);
      exp = w ? er[ii] : ref_mem[ii][a];
      do_req(ii, w, a, d, rd, latn);
      chk($sformatf("rand%0d rdata", n), 32'(rd), 32'(exp));
    end

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_ctrl.md
Name: mem_ctrl

Overview:
Request sequencer directly upstream of the datapath's `mem` block. It accepts single load/store requests from the datapath over a valid/ready handshake and drives `mem`'s MemWrite/MemRead/data_in strobes with clean, mutually exclusive timing. It captures `mem`'s data_out into a read-data register and returns a one-cycle response pulse. One request is in flight at a time. Memory width is 16 bits.

Parameters:
ADDR_W, 8, width of request and memory address.
READ_LAT, 1, number of cycles MemRead is held before data_out is sampled (must be ≥1).

Ports:
clk  in  1  system clock, rising edge.
reset  in  1  asynchronous, active-low reset (0 = reset asserted).
req_valid  in  1  datapath request strobe.
req_ready  out  1  controller can accept a request.
req_we  in  1  1 = store, 0 = load.
req_addr  in  ADDR_W  request address.
req_wdata  in  16  store data.
rsp_valid  out  1  one-cycle completion pulse (load and store).
rsp_rdata  out  16  last loaded word; held until the next load completes.
MemWrite  out  1  write strobe to mem.
MemRead  out  1  read strobe to mem.
mem_addr  out  ADDR_W  address to mem.
mem_din  out  16  to mem data_in.
mem_dout  in  16  from mem data_out.

Behaviour:
- All outputs are registered (Moore). While reset=0, everything is asynchronously forced low/zero: state=IDLE, req_ready=0, rsp_valid=0, MemWrite=0, MemRead=0, mem_addr=0, mem_din=0, rsp_rdata=0, latency counter=0.
- req_ready rises in the first cycle after reset is released.
- State machine:
  - IDLE: req_ready=1. On a rising edge with req_valid&&req_ready, latch we/addr/wdata into mem_addr/mem_din, clear req_ready, and go to WR if we=1, otherwise RD.
  - WR: MemWrite=1 for exactly one cycle; mem captures the data on the closing edge. Next state is RSP.
  - RD: MemRead=1 for READ_LAT consecutive cycles, counted by a counter. On the edge ending the last RD cycle, capture mem_dout into rsp_rdata. Next state is RSP.
  - RSP: rsp_valid=1 for one cycle and all strobes are 0. Next state is IDLE, with req_ready=1 in the following cycle.
- Latency, with the request accepted at edge k:
  - store: MemWrite is high in cycle k, rsp_valid in cycle k+1, req_ready in cycle k+2.
  - load: MemRead is high in cycles k .. k+READ_LAT-1, rsp_valid in cycle k+READ_LAT, req_ready in cycle k+READ_LAT+1.
- Invariant: MemRead&&MemWrite is never 1.
- mem_addr and mem_din are stable for the whole WR/RD phase. They hold their last values in IDLE/RSP.
- req_valid while req_ready=0 is ignored. Request inputs are not sampled and no queueing is done. The requester must hold the request until accepted.
- rsp_valid has no backpressure.
- rsp_rdata is unchanged by stores.
- Reset asserted mid-operation aborts the access: strobes drop immediately and no rsp_valid is produced. The aborted request is lost.
- The address is passed straight through with no arithmetic and no wrap handling.

Decomposition:
- Shared package `mem_if_pkg`:
  - DATA_W=16
  - state encoding localparams IDLE/WR/RD/RSP (2-bit)
  - READ_LAT default
- No sub-module: the FSM and latency counter live in one module.

Test Plan:
1. Hold reset=0 for 2 cycles -> all outputs 0. Release -> req_ready=1 on the next cycle.
2. Store addr=8'h03, wdata=16'h8888 -> MemWrite=1 for one cycle with mem_addr=03, mem_din=8888, MemRead=0. rsp_valid follows 1 cycle later. req_ready returns 2 cycles after acceptance.
3. Load addr=03 with the mem model returning 16'h8888, READ_LAT=1 -> MemRead for one cycle. rsp_valid=1 with rsp_rdata=8888.
4. READ_LAT=3, load while the model returns 16'h1111 -> MemRead high for exactly 3 cycles. rsp_rdata=1111 on the rsp_valid cycle. A subsequent store leaves rsp_rdata=1111.
5. Assert req_valid with we=1, wdata=16'hADAD while a load is in progress -> not accepted until req_ready. The store executes afterwards. An assertion checks MemRead&&MemWrite never 1 throughout.
6. Assert reset during the second RD cycle (READ_LAT=3) -> MemRead falls asynchronously and no rsp_valid occurs. After release, a new load completes normally.
